vga_write_arbiter: RTL and testbench
====================================

Name: vga_write_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, wren) between up to NUM_REQ drawing engines: stage-select cursor, board renderer, title/clear-screen painter, HUD.
- Each engine raises req, waits for its grant bit, streams pixels while granted, then drops req.
- Round-robin selection, grant held for a whole burst, hold-limit watchdog.
- Sits between the per-screen datapaths and the VGA adapter instance in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- MAX_HOLD, 19200, max cycles one owner may hold the port while others wait (one full 160x120 frame).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level, held for the whole burst.
- x_in  in  NUM_REQ*X_W  flattened x buses; requester i at [i*X_W +: X_W].
- y_in  in  NUM_REQ*Y_W  flattened y buses.
- colour_in  in  NUM_REQ*C_W  flattened colour buses.
- wren_in  in  NUM_REQ  per-requester pixel write strobe.
- grant  out  NUM_REQ  one-hot grant, registered.
- x  out  X_W  to VGA adapter, registered.
- y  out  Y_W  to VGA adapter, registered.
- colour  out  C_W  to VGA adapter, registered.
- wren  out  1  to VGA adapter, registered.
- busy  out  1  high in any state other than S_IDLE.
- timeout  out  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
Reset values:
- grant=0, x=0, y=0, colour=0, wren=0, busy=0, timeout=0.
- owner=0, last_owner=NUM_REQ-1, so requester 0 wins first; hold_cnt=0; state=S_IDLE.

States:
- S_IDLE: if req!=0, pick the first set req bit scanning last_owner+1, last_owner+2, ... (mod NUM_REQ). Latch owner, go to S_GRANT. grant[owner] rises on the clock edge that enters S_GRANT, i.e. 1 cycle after req is seen.
- S_GRANT: each cycle register x<=x_in[owner], y<=y_in[owner], colour<=colour_in[owner], wren<=wren_in[owner]. Pixel latency is 1 cycle from requester to adapter. hold_cnt increments.
  - If req[owner]==0: go to S_RELEASE.
  - Else if hold_cnt==MAX_HOLD-1 and any other req bit is set: go to S_RELEASE and pulse timeout for 1 cycle.
  - If hold_cnt reaches MAX_HOLD-1 with no other requester: hold_cnt saturates and the grant continues.
- S_RELEASE: grant=0, wren<=0, last_owner<=owner, hold_cnt<=0. Go to S_IDLE unconditionally. This gives 1 dead cycle between owners, so no pixel can mix two sources.

Rules:
- wren_in, x_in, y_in and colour_in from non-owners are ignored. x/y/colour outputs hold their last value when not in S_GRANT; wren is 0 outside S_GRANT.
- Simultaneous requests: round-robin order only. The just-released owner has the lowest priority for the next pick.
- The owner dropping req and re-raising it in the same S_RELEASE cycle is treated as a new request, arbitrated normally in S_IDLE.
- A revoked owner that keeps req high is re-queued and is re-granted only after every other pending requester has had a turn.
- A req that drops while in S_IDLE before being granted is never granted.
- reset asserted mid-burst forces all outputs to reset values on the next edge; wren=0 on that edge.
- Minimum per-burst overhead is 2 cycles: grant latency plus the release cycle.

Decomposition:
- Shared package: state encodings (S_IDLE=2'd0, S_GRANT=2'd1, S_RELEASE=2'd2) and the default coordinate/colour widths used by every drawing engine.
- One sub-module, rr_pick: combinational round-robin picker (inputs req and last_owner; outputs valid and index). The FSM, hold counter and output mux stay in the top module.

Test Plan:
- Reset then req=4'b0001 at cycle 0 -> grant=0001 at cycle 1; wren_in[0] pulsed with x_in=8'd6, y_in=7'd54, colour_in=3'b111 at cycle 2 -> wren=1, x=6, y=54, colour=7 at cycle 3.
- req=4'b1010 simultaneously after reset -> requester 1 granted first. Drop req[1] -> S_RELEASE (grant=0 for 1 cycle), then grant=1000.
- Requester 2 holds req and streams wren continuously with MAX_HOLD=16 while req[0]=1 -> revoked after 16 cycles of S_GRANT, timeout pulses once, grant moves to 0001. Requester 2 is re-granted only after requester 0 releases.
- Requester 0 owns the port while requester 3 toggles wren_in[3]=1 with x_in=8'd100 -> output x never shows 100; wren follows only wren_in[0].
- Assert reset during a 225-pixel cursor burst -> next edge grant=0, wren=0, busy=0. After release of reset, req=0001 is granted within 1 cycle.
- Single requester holding req for more than MAX_HOLD cycles with no contention -> no timeout, grant stays high, hold_cnt saturates.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// Shared types and default widths for the VGA write-port arbiter and the
// drawing engines that feed it.
package vga_write_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } arb_state_e;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_X_W      = 8;
   localparam int unsigned DEF_Y_W      = 7;
   localparam int unsigned DEF_C_W      = 3;
   localparam int unsigned DEF_MAX_HOLD = 19200;

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_owner,
// wrapping modulo NUM_REQ, so last_owner itself is examined last.
module rr_pick
   import vga_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned IDX_W   = $clog2(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   always_comb begin
      int unsigned cand;
      valid = 1'b0;
      index = '0;
      cand  = 0;
      for (int unsigned step = 1; step <= NUM_REQ; step++) begin
         cand = 32'(last_owner) + step;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         // constant bit index per iteration keeps the compare a simple AND tree
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!valid && (j == cand) && req[j]) begin
               valid = 1'b1;
               index = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter write port between NUM_REQ drawing engines with
// round-robin burst grants, a dead release cycle and a hold-limit watchdog.
module vga_write_arbiter
   import vga_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned X_W      = DEF_X_W,
   parameter int unsigned Y_W      = DEF_Y_W,
   parameter int unsigned C_W      = DEF_C_W,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*X_W-1:0] x_in,
   input  logic [NUM_REQ*Y_W-1:0] y_in,
   input  logic [NUM_REQ*C_W-1:0] colour_in,
   input  logic [NUM_REQ-1:0]     wren_in,
   output logic [NUM_REQ-1:0]     grant,
   output logic [X_W-1:0]         x,
   output logic [Y_W-1:0]         y,
   output logic [C_W-1:0]         colour,
   output logic                   wren,
   output logic                   busy,
   output logic                   timeout
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    last_owner_q, last_owner_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [C_W-1:0]      colour_q, colour_d;
   logic                wren_q, wren_d;
   logic                timeout_q, timeout_d;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic                revoke;
   logic                owner_req, others_req;
   logic [X_W-1:0]      sel_x;
   logic [Y_W-1:0]      sel_y;
   logic [C_W-1:0]      sel_colour;
   logic                sel_wren;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (req),
      .last_owner (last_owner_q),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   // Owner mux; every non-owner bus is ignored here.
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_wren   = 1'b0;
      owner_req  = 1'b0;
      others_req = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            sel_x      = x_in[i*X_W +: X_W];
            sel_y      = y_in[i*Y_W +: Y_W];
            sel_colour = colour_in[i*C_W +: C_W];
            sel_wren   = wren_in[i];
            owner_req  = req[i];
         end else if (req[i]) begin
            others_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_IDX;
         hold_cnt_q   <= '0;
         grant_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         wren_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         hold_cnt_q   <= hold_cnt_d;
         grant_q      <= grant_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_q     <= colour_d;
         wren_q       <= wren_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      hold_cnt_d   = hold_cnt_q;
      revoke       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // saturates so an uncontended owner keeps the port indefinitely
            if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (!owner_req) begin
               state_d = S_RELEASE;
            end else if ((hold_cnt_q == HOLD_LAST) && others_req) begin
               state_d = S_RELEASE;
               revoke  = 1'b1;
            end
         end
         S_RELEASE: begin
            last_owner_d = owner_q;
            hold_cnt_d   = '0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The last granted cycle's pixel still reaches the adapter during S_RELEASE.
   always_comb begin
      grant_d   = grant_q;
      x_d       = x_q;
      y_d       = y_q;
      colour_d  = colour_q;
      wren_d    = 1'b0;
      timeout_d = revoke;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d = NUM_REQ'(1) << pick_idx;
            end
         end
         S_GRANT: begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
            wren_d   = sel_wren;
            if (state_d == S_RELEASE) begin
               grant_d = '0;
            end
         end
         default: begin
            grant_d = '0;
         end
      endcase
   end

   assign grant   = grant_q;
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;
   assign wren    = wren_q;
   assign busy    = (state_q != S_IDLE);
   assign timeout = timeout_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: stimulus pushes expected pixels,
// a negedge monitor pops them whenever the adapter write strobe is high.
module tb_vga_write_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned CW = 3;

   logic               clock;
   logic               reset;
   logic [NR-1:0]      req;
   logic [NR*XW-1:0]   x_in;
   logic [NR*YW-1:0]   y_in;
   logic [NR*CW-1:0]   colour_in;
   logic [NR-1:0]      wren_in;
   logic [NR-1:0]      grant;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic [CW-1:0]      colour;
   logic               wren;
   logic               busy;
   logic               timeout;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] sb_q[$];

   vga_write_arbiter #(
      .NUM_REQ  (NR),
      .X_W      (XW),
      .Y_W      (YW),
      .C_W      (CW),
      .MAX_HOLD (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .x_in      (x_in),
      .y_in      (y_in),
      .colour_in (colour_in),
      .wren_in   (wren_in),
      .grant     (grant),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .wren      (wren),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pix(input int unsigned i, input logic [XW-1:0] xv,
                          input logic [YW-1:0] yv, input logic [CW-1:0] cv,
                          input logic w, input logic expect_out);
      x_in[i*XW +: XW]      = xv;
      y_in[i*YW +: YW]      = yv;
      colour_in[i*CW +: CW] = cv;
      wren_in[i]            = w;
      if (expect_out && w) sb_q.push_back(32'({xv, yv, cv}));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req       = '0;
      wren_in   = '0;
      x_in      = '0;
      y_in      = '0;
      colour_in = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every adapter write must match the next queued pixel.
   always @(negedge clock) begin
      if (wren === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d required no write (t=%0t)",
                     x, y, colour, $time);
         end else begin
            check("pixel", 32'({x, y, colour}), sb_q.pop_front());
         end
      end
   end

   initial begin
      do_reset();
      check("rst_grant", 32'(grant), 0);
      check("rst_xyc", 32'({x, y, colour}), 0);
      check("rst_wren", 32'(wren), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_timeout", 32'(timeout), 0);

      // Single pixel, 1-cycle grant latency and 1-cycle pixel latency
      req = 4'b0001;
      tick();
      check("t1_grant", 32'(grant), 32'b0001);
      check("t1_busy", 32'(busy), 1);
      set_pix(0, 8'd6, 7'd54, 3'd7, 1'b1, 1'b1);
      tick();
      check("t1_wren", 32'(wren), 1);
      set_pix(0, 8'd6, 7'd54, 3'd7, 1'b0, 1'b0);
      req = '0;
      tick();
      check("t1_rel_grant", 32'(grant), 0);
      check("t1_rel_busy", 32'(busy), 1);
      tick();
      check("t1_idle_busy", 32'(busy), 0);

      // Simultaneous requests: round robin from last_owner=3
      do_reset();
      req = 4'b1010;
      tick();
      check("t2_first", 32'(grant), 32'b0010);
      req = 4'b1000;
      tick();
      check("t2_release", 32'(grant), 0);
      tick();
      check("t2_idle", 32'(grant), 0);
      tick();
      check("t2_second", 32'(grant), 32'b1000);
      req = '0;
      tick();
      tick();

      // Watchdog revoke after 16 granted cycles while requester 0 waits
      do_reset();
      req = 4'b0100;
      tick();
      check("t3_grant2", 32'(grant), 32'b0100);
      req = 4'b0101;
      for (int unsigned k = 0; k < 16; k++) begin
         set_pix(2, XW'(40 + k), YW'(60 + k), CW'(k), 1'b1, 1'b1);
         tick();
         if (k < 15) begin
            check("t3_hold_grant", 32'(grant), 32'b0100);
            check("t3_hold_timeout", 32'(timeout), 0);
         end else begin
            check("t3_revoke_timeout", 32'(timeout), 1);
            check("t3_revoke_grant", 32'(grant), 0);
         end
      end
      set_pix(2, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
      tick();
      check("t3_timeout_once", 32'(timeout), 0);
      check("t3_idle_wren", 32'(wren), 0);
      tick();
      check("t3_grant0", 32'(grant), 32'b0001);
      for (int unsigned k = 0; k < 3; k++) begin
         tick();
         check("t3_keep0", 32'(grant), 32'b0001);
      end
      req = 4'b0100;
      tick();
      tick();
      tick();
      check("t3_regrant2", 32'(grant), 32'b0100);
      req = '0;
      tick();
      tick();

      // Non-owner buses are ignored
      do_reset();
      req = 4'b1001;
      tick();
      check("t4_grant0", 32'(grant), 32'b0001);
      for (int unsigned k = 0; k < 6; k++) begin
         set_pix(0, XW'(20 + k), YW'(k), CW'(k), 1'(k % 2), 1'b1);
         set_pix(3, 8'd100, 7'd99, 3'd5, 1'b1, 1'b0);
         tick();
         check("t4_x", 32'(x), 20 + k);
         check("t4_wren", 32'(wren), k % 2);
      end
      req     = '0;
      wren_in = '0;
      tick();
      tick();

      // Reset in the middle of a long uncontended burst
      do_reset();
      req = 4'b0001;
      tick();
      for (int unsigned k = 0; k < 100; k++) begin
         set_pix(0, XW'(k), YW'(k % 120), CW'(k % 8), 1'b1, 1'b1);
         tick();
      end
      check("t5_no_timeout", 32'(timeout), 0);
      set_pix(0, 8'd200, 7'd1, 3'd1, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      check("t5_grant", 32'(grant), 0);
      check("t5_wren", 32'(wren), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_x", 32'(x), 0);
      reset   = 1'b0;
      wren_in = '0;
      tick();
      check("t5_regrant", 32'(grant), 32'b0001);
      req = '0;
      tick();
      tick();

      // Saturated hold counter: no timeout alone, immediate revoke on contention
      do_reset();
      req = 4'b0010;
      tick();
      for (int unsigned k = 0; k < 40; k++) begin
         tick();
         check("t6_grant", 32'(grant), 32'b0010);
         check("t6_timeout", 32'(timeout), 0);
      end
      req = 4'b0011;
      tick();
      check("t6_revoke_timeout", 32'(timeout), 1);
      check("t6_revoke_grant", 32'(grant), 0);
      req = '0;
      tick();
      tick();

      check("sb_drained", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
